// File: rtl/sram22_port_ctrl.sv
// sram22_port_ctrl: request/response front end for a 1RW SRAM macro with zero-fill init and a 2-entry read FIFO
module sram22_port_ctrl #(
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int WMASK_WIDTH   = 4,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   init_done,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] icnt;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic wptr, rptr, inflight, run, pop, acc;
  logic [1:0] count;
  logic [2:0] occ;
  assign rsp_valid = count != 2'd0;
  assign rsp_rdata = fifo[rptr];
  assign init_done = run;
  // handshakes, next state and SRAM port mux; reads are refused whenever the FIFO could overflow
  always_comb begin
    run = state == RUN;
    pop = rsp_valid & rsp_ready;
    occ = 3'(count) + 3'(inflight) - 3'(pop);
    req_ready = run & (req_we | (occ < 3'd2));
    acc = req_valid & req_ready;
    state_nx = (!run && &icnt) ? RUN : state;
    sram_we = ~rst & (run ? acc & req_we : 1'b1);
    sram_wmask = run ? req_wmask : '1;
    sram_addr = run ? req_addr : icnt;
    sram_din = run ? req_wdata : '0;
  end
  // state register and zero-fill address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_ON_RESET ? INIT : RUN;
      icnt <= '0;
    end else begin
      state <= state_nx;
      icnt <= run ? icnt : icnt + 1'b1;
    end
  end
  // read tracking: macro data arrives the cycle after issue and is pushed while inflight
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      count <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      inflight <= acc & ~req_we;
      count <= 2'(count + {1'b0, inflight} - {1'b0, pop});
      wptr <= wptr ^ inflight;
      rptr <= rptr ^ pop;
    end
  end
  // FIFO storage needs no reset; the count alone decides what is valid
  always_ff @(posedge clk) begin
    if (inflight) fifo[wptr] <= sram_dout;
  end
endmodule

// File: tb/tb_sram22_port_ctrl.sv
// tb_sram22_port_ctrl: directed checks of init fill, masked writes, read pipeline, backpressure and reset
module tb_sram22_port_ctrl;
  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [3:0] req_wmask = 4'h0;
  logic [8:0] req_addr = 9'd0;
  logic [31:0] req_wdata = 32'd0;
  logic rsp_valid, rsp_ready = 1'b1, init_done;
  logic [31:0] rsp_rdata;
  logic sram_we;
  logic [3:0] sram_wmask;
  logic [8:0] sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic [31:0] mem [512];
  logic [31:0] q [$];
  int n_cmp = 0, n_err = 0, nrsp = 0, nrsp0;

  always #5 clk = ~clk;

  sram22_port_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .init_done(init_done), .sram_we(sram_we),
    .sram_wmask(sram_wmask), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // behavioural 1RW macro with byte mask and one-cycle read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (sram_we) begin
      for (int b = 0; b < 4; b++) if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
    end
    sram_dout <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] m, input logic [8:0] a, input logic [31:0] d);
    req_valid = v;
    req_we = we;
    req_wmask = m;
    req_addr = a;
    req_wdata = d;
    #1;
  endtask

  task automatic wait_init;
    int n;
    n = 0;
    chk("init_addr0", sram_addr, 0);
    chk("init_we", sram_we, 1);
    while (!init_done && n < 600) begin
      step;
      n++;
      if (!init_done) chk("init_addr", sram_addr, n);
    end
    chk("init_len", n, 512);
  endtask

  // scoreboard: every popped response must match the next expected value in order
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        chk("rsp_data", rsp_rdata, q.pop_front());
        nrsp++;
      end
    end
  end

  initial begin
    repeat (3) step;
    chk("rst_we", sram_we, 0);
    chk("rst_done", init_done, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    preload = 1'b0;
    #1;
    wait_init;
    chk("run_ready", req_ready, 1);
    for (int a = 0; a < 512; a++) begin
      drive(1, 0, 4'h0, 9'(a), 32'd0);
      q.push_back(32'd0);
      step;
    end
    drive(0, 0, 4'h0, 9'd0, 32'd0);
    repeat (3) step;
    chk("init_readback_all", q.size(), 0);

    drive(1, 1, 4'hF, 9'd5, 32'h1122_3344);
    step;
    drive(1, 1, 4'h5, 9'd5, 32'hAABB_CCDD);
    chk("wr_ready", req_ready, 1);
    chk("wr_we", sram_we, 1);
    chk("wr_addr", sram_addr, 5);
    chk("wr_mask", sram_wmask, 5);
    chk("wr_din", sram_din, 32'hAABB_CCDD);
    step;
    drive(1, 0, 4'hF, 9'd5, 32'hDEAD_BEEF);
    chk("rd_no_we", sram_we, 0);
    q.push_back(32'h11BB_33DD);
    step;
    drive(0, 0, 4'h0, 9'd0, 32'd0);
    chk("lat_early", rsp_valid, 0);
    step;
    chk("lat_valid", rsp_valid, 1);
    chk("lat_data", rsp_rdata, 32'h11BB_33DD);
    step;

    for (int a = 0; a < 16; a++) begin
      drive(1, 1, 4'hF, 9'(a), 32'hA5A5_0000 | 32'(a));
      step;
    end
    nrsp0 = nrsp;
    for (int a = 0; a < 16; a++) begin
      drive(1, 0, 4'h0, 9'(a), 32'd0);
      chk("b2b_ready", req_ready, 1);
      q.push_back(32'hA5A5_0000 | 32'(a));
      step;
      chk("b2b_valid", rsp_valid, a >= 1);
    end
    drive(0, 0, 4'h0, 9'd0, 32'd0);
    step;
    chk("b2b_last", rsp_valid, 1);
    step;
    chk("b2b_idle", rsp_valid, 0);
    chk("b2b_count", nrsp - nrsp0, 16);

    rsp_ready = 1'b0;
    drive(1, 0, 4'h0, 9'd0, 32'd0);
    chk("bp_rd0", req_ready, 1);
    q.push_back(32'hA5A5_0000);
    step;
    drive(1, 0, 4'h0, 9'd1, 32'd0);
    chk("bp_rd1", req_ready, 1);
    q.push_back(32'hA5A5_0001);
    step;
    drive(1, 0, 4'h0, 9'd2, 32'd0);
    chk("bp_rd_blocked", req_ready, 0);
    chk("bp_rd_no_we", sram_we, 0);
    drive(1, 1, 4'hF, 9'd20, 32'h1234_5678);
    chk("bp_wr_ready", req_ready, 1);
    chk("bp_wr_we", sram_we, 1);
    step;
    drive(1, 0, 4'h0, 9'd2, 32'd0);
    chk("bp_full_blocked", req_ready, 0);
    chk("bp_valid", rsp_valid, 1);
    chk("bp_head", rsp_rdata, 32'hA5A5_0000);
    step;
    drive(0, 0, 4'h0, 9'd0, 32'd0);
    step;
    chk("bp_hold", rsp_rdata, 32'hA5A5_0000);
    rsp_ready = 1'b1;
    drive(1, 0, 4'h0, 9'd3, 32'd0);
    chk("pop_accept", req_ready, 1);
    q.push_back(32'hA5A5_0003);
    step;
    drive(0, 0, 4'h0, 9'd0, 32'd0);
    repeat (4) step;
    chk("drain_empty", q.size(), 0);
    chk("drain_valid", rsp_valid, 0);

    rsp_ready = 1'b0;
    drive(1, 0, 4'h0, 9'd1, 32'd0);
    step;
    drive(1, 0, 4'h0, 9'd2, 32'd0);
    step;
    drive(0, 0, 4'h0, 9'd0, 32'd0);
    chk("pre_rst_valid", rsp_valid, 1);
    rst = 1'b1;
    step;
    q.delete();
    chk("rst2_valid", rsp_valid, 0);
    chk("rst2_we", sram_we, 0);
    chk("rst2_done", init_done, 0);
    rsp_ready = 1'b1;
    step;
    rst = 1'b0;
    #1;
    repeat (10) step;
    chk("mid_init_addr", sram_addr, 10);
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    wait_init;
    repeat (3) step;
    chk("no_stale_rsp", rsp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
